os_drain_collector: RTL and testbench

- Downstream neighbour of the output-stationary PE array.
- Sequences the drain phase by driving the os_drain control bit for exactly ARRAY_ROWS cycles, during which PE accumulators shift down one row per cycle.
- Captures the bottom-row results each drain cycle and requantizes each 32-bit accumulator to signed 8-bit, with rounding shift, optional ReLU and saturation.
- Buffers the full tile, then streams it out one row per valid/ready handshake, in row order 0..ARRAY_ROWS-1.

---
 rtl/os_drain_collector_pkg.sv | 24 ++
 rtl/os_drain_collector_requant_sat.sv | 50 +++++
 rtl/os_drain_collector.sv | 146 ++++++++++++++
 tb/tb_os_drain_collector.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_drain_collector_pkg.sv
// Shared definitions for the output-stationary drain collector: FSM state
// encoding, PE operation-signal bit positions and default widths.
package os_drain_collector_pkg;

    // Collector sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Bit positions inside the PE operation signal
    localparam int OP_MODE_BIT     = 2;
    localparam int OP_OS_DRAIN_BIT = 1;
    localparam int OP_WGT_LOAD_BIT = 0;

    // Default geometry and widths
    localparam int DEF_ARRAY_ROWS   = 8;
    localparam int DEF_ARRAY_COLS   = 8;
    localparam int DEF_PE_OUT_WIDTH = 32;
    localparam int DEF_OUT_WIDTH    = 8;
    localparam int DEF_SHIFT_WIDTH  = 5;

endpackage : os_drain_collector_pkg

// File: rtl/os_drain_collector_requant_sat.sv
// Single-lane requantizer: round-half-up arithmetic right shift of a signed
// accumulator, optional ReLU, then saturation to the signed output range.
// Purely combinational; the top instantiates one per PE column.
module requant_sat
    import os_drain_collector_pkg::*;
#(
    parameter int PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH
) (
    input  logic [PE_OUT_WIDTH-1:0] i_x,
    input  logic [SHIFT_WIDTH-1:0]  i_shift,
    input  logic                    i_relu,
    output logic [OUT_WIDTH-1:0]    o_y
);

    localparam int W = PE_OUT_WIDTH;

    // Saturation bounds, sign-extended to the one-bit-wider working width
    localparam logic signed [W:0] SAT_MAX = {{(W-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W:0] SAT_MIN = {{(W-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // One extra bit of headroom so x + rnd can never wrap
    logic signed [W:0] w_x_ext;
    logic signed [W:0] w_rnd;
    logic signed [W:0] w_sum;
    logic signed [W:0] w_shr;
    logic signed [W:0] w_relu;

    // Round, shift, clamp negatives when enabled, then saturate
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave a latch behind.
        w_rnd   = '0;
        w_x_ext = {i_x[W-1], i_x};
        if (i_shift != '0) begin
            w_rnd[i_shift - 1'b1] = 1'b1;
        end
        w_sum  = w_x_ext + w_rnd;
        w_shr  = w_sum >>> i_shift;
        w_relu = (i_relu && w_shr[W]) ? '0 : w_shr;
        if (w_relu > SAT_MAX) begin
            o_y = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_relu < SAT_MIN) begin
            o_y = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            o_y = w_relu[OUT_WIDTH-1:0];
        end
    end

endmodule : requant_sat

// File: rtl/os_drain_collector.sv
// Drain collector for the output-stationary PE array. On an accepted start it
// holds the array's drain bit for exactly ARRAY_ROWS cycles, requantizes the
// bottom row seen on each drain edge into a tile buffer (row ARRAY_ROWS-1
// arrives first), then streams the tile out row 0 first over valid/ready.
module os_drain_collector
    import os_drain_collector_pkg::*;
#(
    parameter int ARRAY_ROWS   = DEF_ARRAY_ROWS,
    parameter int ARRAY_COLS   = DEF_ARRAY_COLS,
    parameter int PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [SHIFT_WIDTH-1:0]             cfg_shift,
    input  logic                               cfg_relu,
    output logic                               array_drain,
    input  logic [ARRAY_COLS*PE_OUT_WIDTH-1:0] array_result_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ARRAY_COLS*OUT_WIDTH-1:0]    out_data,
    output logic [$clog2(ARRAY_ROWS)-1:0]      out_row_idx,
    output logic                               busy,
    output logic                               done
);

    localparam int                IDX_W    = $clog2(ARRAY_ROWS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ARRAY_ROWS - 1);

    typedef logic [ARRAY_COLS*OUT_WIDTH-1:0] row_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_drain_cnt;
    logic [IDX_W-1:0]       r_row_idx;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic                   r_relu;
    logic                   r_done;
    row_t                   r_buf [ARRAY_ROWS];

    row_t                   w_req_row;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_start_acc;
    logic                   w_drain_last;
    logic                   w_handshake;
    logic                   w_emit_last;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_drain_last = (r_state == ST_DRAIN) && (r_drain_cnt == LAST_IDX);
    assign w_handshake  = (r_state == ST_EMIT) && out_ready;
    assign w_emit_last  = w_handshake && (r_row_idx == LAST_IDX);

    // Drain step k sees PE row ARRAY_ROWS-1-k on the bottom bus
    assign w_wr_idx = LAST_IDX - r_drain_cnt;

    // One requantizer per PE column, fed with the latched configuration
    for (genvar c = 0; c < ARRAY_COLS; c++) begin : g_lane
        requant_sat #(
            .PE_OUT_WIDTH (PE_OUT_WIDTH),
            .OUT_WIDTH    (OUT_WIDTH),
            .SHIFT_WIDTH  (SHIFT_WIDTH)
        ) u_requant (
            .i_x     (array_result_in[c*PE_OUT_WIDTH +: PE_OUT_WIDTH]),
            .i_shift (r_shift),
            .i_relu  (r_relu),
            .o_y     (w_req_row[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: drain for ARRAY_ROWS edges, emit ARRAY_ROWS rows
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_acc)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_last) w_state_nxt = ST_EMIT;
            ST_EMIT:  if (w_emit_last)  w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch requant configuration only when a start is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_relu  <= 1'b0;
        end else if (w_start_acc) begin
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
        end
    end

    // Drain step counter k, cleared after the last drain edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + IDX_W'(1);
        end
    end

    // Output row pointer, advanced on each accepted row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_idx <= '0;
        end else if (w_handshake) begin
            r_row_idx <= w_emit_last ? '0 : r_row_idx + IDX_W'(1);
        end
    end

    // Completion pulse in the cycle after the final row handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_emit_last;
        end
    end

    // Tile buffer capture; entries are written before they are ever read
    always_ff @(posedge clk) begin
        // NOTE: the row buffer is storage, not control state, so it is deliberately left out of reset.
        if (!reset && (r_state == ST_DRAIN)) begin
            r_buf[w_wr_idx] <= w_req_row;
        end
    end

    assign array_drain = (r_state == ST_DRAIN);
    assign out_valid   = (r_state == ST_EMIT);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign out_row_idx = r_row_idx;
    assign out_data    = r_buf[r_row_idx];

endmodule : os_drain_collector

// File: tb/tb_os_drain_collector.sv
// Self-checking bench for os_drain_collector. A behavioural PE-array model
// shifts rows down while array_drain is high; expected rows are computed from
// the loaded tile and pushed to a scoreboard, popped on each row handshake.
module tb_os_drain_collector;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int PW   = 32;
    localparam int OW   = 8;
    localparam int SW   = 5;
    localparam int IW   = $clog2(ROWS);

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [SW-1:0]        cfg_shift;
    logic                 cfg_relu;
    logic                 array_drain;
    logic [COLS*PW-1:0]   array_result_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [COLS*OW-1:0]   out_data;
    logic [IW-1:0]        out_row_idx;
    logic                 busy;
    logic                 done;

    os_drain_collector #(
        .ARRAY_ROWS   (ROWS),
        .ARRAY_COLS   (COLS),
        .PE_OUT_WIDTH (PW),
        .OUT_WIDTH    (OW),
        .SHIFT_WIDTH  (SW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_shift       (cfg_shift),
        .cfg_relu        (cfg_relu),
        .array_drain     (array_drain),
        .array_result_in (array_result_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row_idx     (out_row_idx),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // PE array model: loadable, shifts down one row per drain edge
    logic signed [PW-1:0] arr  [ROWS][COLS];
    logic signed [PW-1:0] tile [ROWS][COLS];
    logic                 tb_load;

    always @(posedge clk) begin
        if (tb_load) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    arr[r][c] <= tile[r][c];
        end else if (array_drain) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = ROWS - 1; r > 0; r--)
                    arr[r][c] <= arr[r-1][c];
                arr[0][c] <= '0;
            end
        end
    end

    always_comb begin
        array_result_in = '0;
        for (int c = 0; c < COLS; c++)
            array_result_in[c*PW +: PW] = arr[ROWS-1][c];
    end

    // Reference requantizer in wide integer arithmetic
    function automatic logic [OW-1:0] ref_requant(input logic signed [PW-1:0] x, input int s, input bit relu);
        longint y;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        y  = longint'(x);
        if (s > 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
        if (relu && y < 0) y = 0;
        if (y > hi) y = hi;
        else if (y < lo) y = lo;
        return y[OW-1:0];
    endfunction

    typedef struct {
        logic [IW-1:0]      idx;
        logic [COLS*OW-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_expected(input int s, input bit rl);
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.idx  = IW'(r);
            e.data = '0;
            for (int c = 0; c < COLS; c++)
                e.data[c*OW +: OW] = ref_requant(tile[r][c], s, rl);
            sb_q.push_back(e);
        end
    endtask

    // Output monitor: row order/content, hold under stall, done timing, drain length
    bit mon_en   = 1'b0;
    bit done_due = 1'b0;
    int drain_run = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit hs_last;
            hs_last = 1'b0;
            check("done_pulse", done, done_due);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_row", 1, 0);
                end else begin
                    check("row_idx", out_row_idx, sb_q[0].idx);
                    check("row_data", out_data, sb_q[0].data);
                    if (out_ready && !reset) begin
                        hs_last = (sb_q[0].idx == IW'(ROWS - 1));
                        void'(sb_q.pop_front());
                    end
                end
            end
            done_due = hs_last;
            if (reset) begin
                drain_run = 0;
            end else if (array_drain) begin
                drain_run++;
            end else if (drain_run != 0) begin
                check("drain_len", drain_run, ROWS);
                drain_run = 0;
            end
        end
    end

    // Tile builders
    task automatic fill_pattern();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tile[r][c] = PW'(r * 10 + c);
    endtask

    task automatic fill_random(input bit wide);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tile[r][c] = wide ? PW'($urandom) : PW'(int'($urandom_range(0, 4000)) - 2000);
    endtask

    // Accept cycle: load array model and pulse start; returns at #1 into T+1
    task automatic launch_tile(input int s, input bit rl, input bit immediate);
        if (!immediate) begin
            @(posedge clk); #1;
        end
        tb_load   = 1'b1;
        start     = 1'b1;
        cfg_shift = SW'(s);
        cfg_relu  = rl;
        push_expected(s, rl);
        @(posedge clk); #1;
        tb_load = 1'b0;
        start   = 1'b0;
        check("drain_rise", array_drain, 1);
        check("busy_rise", busy, 1);
    endtask

    // Wait for first out_valid, optionally poking start mid-drain
    task automatic wait_valid(input bit poke);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (poke && cyc == 3) begin
                start     = 1'b1;
                cfg_shift = SW'(9);
                cfg_relu  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 4) check("drain_after_poke", array_drain, 1);
        end
        start = 1'b0;
        check("first_valid_latency", cyc, ROWS + 1);
    endtask

    // Consume rows until done; optional stall on one row and start poke in EMIT
    task automatic wait_done(input int stall_row, input int stall_len, input bit poke);
        int n;
        int stalls;
        bit got;
        n = 0; stalls = 0; got = 1'b0;
        while (n < 100) begin
            if (out_valid && int'(out_row_idx) == stall_row && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            start = (poke && n == 1);
            @(posedge clk); #1;
            n++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("done_seen", got, 1);
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
    endtask

    task automatic check_array_zero();
        bit any;
        any = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (arr[r][c] != '0) any = 1'b1;
        check("array_zero", any, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        tb_load   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_drain", array_drain, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", out_row_idx, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Ordering: lane c of row r = r*10+c, passthrough config
        fill_pattern();
        launch_tile(0, 1'b0, 1'b0);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);
        check_array_zero();

        // Rounding: 40, -40, 8, -9 with shift 4
        fill_random(1'b0);
        tile[0][0] = 40; tile[0][1] = -40; tile[0][2] = 8; tile[0][3] = -9;
        launch_tile(4, 1'b0, 1'b0);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);

        // Saturation: 300, -300, 127, -128 with shift 0, plus wide random rows
        fill_random(1'b1);
        tile[0][0] = 300; tile[0][1] = -300; tile[0][2] = 127; tile[0][3] = -128;
        launch_tile(0, 1'b0, 1'b0);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);

        // ReLU: -5, 300 with shift 0
        fill_random(1'b0);
        tile[0][0] = -5; tile[0][1] = 300;
        launch_tile(0, 1'b1, 1'b0);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);

        // Backpressure: 3 stall cycles on row 2, shift 3
        fill_random(1'b0);
        launch_tile(3, 1'b0, 1'b0);
        wait_valid(1'b0);
        wait_done(2, 3, 1'b0);

        // Busy: start poked during DRAIN and EMIT must be ignored
        fill_random(1'b1);
        launch_tile(2, 1'b0, 1'b0);
        wait_valid(1'b1);
        wait_done(-1, 0, 1'b1);

        // Start in the done cycle is accepted immediately
        fill_random(1'b1);
        launch_tile(6, 1'b1, 1'b1);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);

        // Reset mid-drain at k=3, then a normal tile
        fill_random(1'b0);
        launch_tile(1, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        check("mid_rst_drain", array_drain, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        fill_random(1'b1);
        launch_tile(5, 1'b0, 1'b0);
        wait_valid(1'b0);
        wait_done(-1, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_os_drain_collector
